bcd_counter_multi: RTL and testbench

- Parametrised multi-digit BCD up/down counter with an integrated prescaler.
- Next generation of the two-digit divider-plus-counter pair. Digit count and divide ratio are generic.
- Adds synchronous clear, parallel BCD load, enable gating, and a selectable wrap or saturate mode.
- Adds terminal-count, limit and load-error flags, so it can drive display, timer and event-count paths.

---
 rtl/bcd_counter_multi.sv | 125 ++++++++++++
 tb/tb_bcd_counter_multi.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_multi.sv
// Multi-digit BCD up/down counter with built-in prescaler,
// wrap/saturate limits, parallel load and status flags.
module bcd_counter_multi #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_RATIO  = 100000000,
  localparam int DIV_W =
    (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up_down,
  input  logic                    sat_mode,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    tick,
  output logic                    carry,
  output logic                    at_max,
  output logic                    at_min,
  output logic                    load_err
);

  localparam int CW = 4 * NUM_DIGITS;
  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(DIV_RATIO - 1);

  logic [DIV_W-1:0] psc_q;
  logic [CW-1:0]    count_q;
  logic             psc_last;

  logic [CW-1:0]    inc_val;
  logic [CW-1:0]    dec_val;
  logic [CW-1:0]    ld_val;
  logic             ld_bad;
  logic             all9;
  logic             all0;
  logic             cy;
  logic             bw;
  logic [3:0]       dig;
  logic [3:0]       ldig;

  assign psc_last = (psc_q == DIV_LAST);

  // cy/bw ripple from digit 0 upward; their final value
  // doubles as the all-nines / all-zeros detect.
  always_comb begin
    inc_val = '0;
    dec_val = '0;
    ld_val  = '0;
    ld_bad  = 1'b0;
    cy      = 1'b1;
    bw      = 1'b1;
    dig     = '0;
    ldig    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dig = count_q[4*i +: 4];
      if (cy)
        inc_val[4*i +: 4] =
          (dig == 4'd9) ? 4'd0 : dig + 4'd1;
      else
        inc_val[4*i +: 4] = dig;
      if (bw)
        dec_val[4*i +: 4] =
          (dig == 4'd0) ? 4'd9 : dig - 4'd1;
      else
        dec_val[4*i +: 4] = dig;
      cy = cy & (dig == 4'd9);
      bw = bw & (dig == 4'd0);
      ldig = load_value[4*i +: 4];
      if (ldig > 4'd9) begin
        ld_val[4*i +: 4] = 4'd0;
        ld_bad           = 1'b1;
      end else begin
        ld_val[4*i +: 4] = ldig;
      end
    end
    all9 = cy;
    all0 = bw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      psc_q    <= '0;
      tick     <= 1'b0;
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tick     <= 1'b0;
      carry    <= 1'b0;
      load_err <= 1'b0;
      if (clear) begin
        count_q <= '0;
        psc_q   <= '0;
      end else if (load) begin
        count_q  <= ld_val;
        psc_q    <= '0;
        load_err <= ld_bad;
      end else if (en) begin
        if (psc_last) begin
          psc_q <= '0;
          tick  <= 1'b1;
          if (up_down) begin
            if (!(all9 && sat_mode))
              count_q <= inc_val;
            carry <= all9 & ~sat_mode;
          end else begin
            if (!(all0 && sat_mode))
              count_q <= dec_val;
            carry <= all0 & ~sat_mode;
          end
        end else begin
          psc_q <= psc_q + DIV_W'(1);
        end
      end
    end
  end

  assign count  = count_q;
  assign at_max = all9;
  assign at_min = all0;

endmodule

// File: tb/tb_bcd_counter_multi.sv
// Randomised bench for bcd_counter_multi (2 digits, divide by 4)
// against an integer-valued reference model.
module tb_bcd_counter_multi;

  localparam int ND  = 2;
  localparam int DIV = 4;
  localparam int MAXV = 99;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up_down;
  logic       sat_mode;
  logic       clear;
  logic       load;
  logic [7:0] load_value;
  logic [7:0] count;
  logic       tick;
  logic       carry;
  logic       at_max;
  logic       at_min;
  logic       load_err;

  int total = 0;
  int bad   = 0;

  int m_val, m_psc;
  bit m_tick, m_carry, m_lerr;

  always #5 clk = ~clk;

  bcd_counter_multi #(
    .NUM_DIGITS(ND),
    .DIV_RATIO (DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .up_down   (up_down),
    .sat_mode  (sat_mode),
    .clear     (clear),
    .load      (load),
    .load_value(load_value),
    .count     (count),
    .tick      (tick),
    .carry     (carry),
    .at_max    (at_max),
    .at_min    (at_min),
    .load_err  (load_err)
  );

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic model_reset();
    m_val = 0; m_psc = 0;
    m_tick = 0; m_carry = 0; m_lerr = 0;
  endtask

  task automatic model_edge(bit e, bit ud, bit sat, bit clr,
                            bit ld, logic [7:0] ldv);
    int hi, lo;
    m_tick = 0; m_carry = 0; m_lerr = 0;
    if (clr) begin
      m_val = 0; m_psc = 0;
    end else if (ld) begin
      hi = int'(ldv[7:4]);
      lo = int'(ldv[3:0]);
      if (hi > 9 || lo > 9) m_lerr = 1;
      if (hi > 9) hi = 0;
      if (lo > 9) lo = 0;
      m_val = hi * 10 + lo;
      m_psc = 0;
    end else if (e) begin
      if (m_psc == DIV - 1) begin
        m_psc = 0;
        m_tick = 1;
        if (ud) begin
          if (m_val == MAXV) begin
            if (!sat) begin m_val = 0; m_carry = 1; end
          end else m_val++;
        end else begin
          if (m_val == 0) begin
            if (!sat) begin m_val = MAXV; m_carry = 1; end
          end else m_val--;
        end
      end else m_psc++;
    end
  endtask

  task automatic check_all();
    chk("count",    count,    to_bcd(m_val));
    chk("tick",     tick,     m_tick);
    chk("carry",    carry,    m_carry);
    chk("at_max",   at_max,   m_val == MAXV);
    chk("at_min",   at_min,   m_val == 0);
    chk("load_err", load_err, m_lerr);
  endtask

  task automatic cyc(bit e, bit ud, bit sat, bit clr,
                     bit ld, logic [7:0] ldv);
    en = e; up_down = ud; sat_mode = sat;
    clear = clr; load = ld; load_value = ldv;
    @(posedge clk);
    model_edge(e, ud, sat, clr, ld, ldv);
    #1;
    check_all();
  endtask

  task automatic run_to_psc(int target, bit ud);
    for (int i = 0; i < 8 && m_psc != target; i++)
      cyc(1, ud, 0, 0, 0, 8'h00);
    chk("psc_reach", m_psc, target);
  endtask

  logic [7:0] frozen;

  initial begin
    rst = 1; en = 0; up_down = 1; sat_mode = 0;
    clear = 0; load = 0; load_value = '0;
    model_reset();
    #12;
    chk("rst_count", count, 8'h00);
    chk("rst_min",   at_min, 1'b1);
    chk("rst_max",   at_max, 1'b0);
    chk("rst_tick",  tick,   1'b0);
    rst = 0;

    // up count from reset, 00..10
    for (int i = 0; i < 4 * 10; i++)
      cyc(1, 1, 0, 0, 0, 8'h00);
    chk("up_10", count, 8'h10);
    cyc(0, 1, 0, 0, 1, 8'h98);
    for (int i = 0; i < 8; i++)
      cyc(1, 1, 0, 0, 0, 8'h00);
    chk("up_wrap", count, 8'h00);

    // down with saturation, then wrap
    cyc(0, 0, 1, 0, 1, 8'h01);
    for (int i = 0; i < 16; i++)
      cyc(1, 0, 1, 0, 0, 8'h00);
    chk("sat_hold", count, 8'h00);
    for (int i = 0; i < 4; i++)
      cyc(1, 0, 0, 0, 0, 8'h00);
    chk("dn_wrap", count, 8'h99);

    // illegal and legal loads
    cyc(0, 1, 0, 0, 1, 8'h5C);
    chk("ld_5c", count, 8'h50);
    chk("ld_5c_err", load_err, 1'b1);
    cyc(0, 1, 0, 0, 0, 8'h00);
    chk("ld_err_once", load_err, 1'b0);
    cyc(0, 1, 0, 0, 1, 8'h42);
    chk("ld_42", count, 8'h42);

    // clear+load on a step cycle
    run_to_psc(3, 1);
    cyc(1, 1, 0, 1, 1, 8'h55);
    chk("prio_cnt", count, 8'h00);
    for (int i = 0; i < 3; i++)
      cyc(1, 1, 0, 0, 0, 8'h00);
    chk("prio_early", tick, 1'b0);
    cyc(1, 1, 0, 0, 0, 8'h00);
    chk("prio_tick4", tick, 1'b1);

    // enable gating with prescaler at 2
    run_to_psc(2, 1);
    frozen = count;
    for (int i = 0; i < 10; i++)
      cyc(0, 1, 0, 0, 0, 8'h00);
    chk("en_frozen", count, frozen);
    cyc(1, 1, 0, 0, 0, 8'h00);
    chk("en_tick1", tick, 1'b0);
    cyc(1, 1, 0, 0, 0, 8'h00);
    chk("en_tick2", tick, 1'b1);

    // asynchronous reset mid-count at 37
    cyc(0, 1, 0, 0, 1, 8'h36);
    for (int i = 0; i < 8 && m_val != 37; i++)
      cyc(1, 1, 0, 0, 0, 8'h00);
    chk("mid_37", count, 8'h37);
    #3 rst = 1;
    #1;
    chk("arst_count", count, 8'h00);
    chk("arst_min",   at_min, 1'b1);
    chk("arst_max",   at_max, 1'b0);
    chk("arst_tick",  tick,   1'b0);
    chk("arst_carry", carry,  1'b0);
    #1 rst = 0;
    model_reset();

    // randomised mix
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 9) != 0,
          1'($urandom),
          1'($urandom),
          $urandom_range(0, 49) == 0,
          $urandom_range(0, 19) == 0,
          8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
